// File: rtl/conv_engine_2d_cfg_pkg.sv
// Shared types and constants for the 3x3 configurable convolution engine.
package conv_engine_2d_cfg_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} conv_state_e;

  localparam int NumTaps = 9;

  // Sobel-X, row-major, row 0 = oldest line, column 0 = oldest pixel.
  localparam int SobelXCoef [NumTaps] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};

  // Zero-extended pixel times signed coefficient, nine of them summed.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned coef_w);
    return data_w + coef_w + 5;
  endfunction

endpackage

// File: rtl/conv_window_3x3.sv
// Two line buffers feeding a 3x3 sliding window; shifts only on shift_en.
module conv_window_3x3
  import conv_engine_2d_cfg_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 32,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                         clk,
  input  logic                         shift_en,
  input  logic [DATA_W-1:0]            pixel_in,
  output logic [2:0][2:0][DATA_W-1:0]  window
);

  logic [IMG_WIDTH-1:0][DATA_W-1:0] line1_q, line2_q;
  logic [2:0][2:0][DATA_W-1:0]      win_q;

  // Tail of each line buffer is the pixel exactly one (two) rows above the incoming one.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      line1_q <= {line1_q[IMG_WIDTH-2:0], pixel_in};
      line2_q <= {line2_q[IMG_WIDTH-2:0], line1_q[IMG_WIDTH-1]};
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[2][2] <= pixel_in;
      win_q[1][2] <= line1_q[IMG_WIDTH-1];
      win_q[0][2] <= line2_q[IMG_WIDTH-1];
    end
  end

  assign window = win_q;

endmodule

// File: rtl/conv_engine_2d_cfg.sv
// Streaming 3x3 convolution with programmable coefficients, shift, ReLU and saturation.
module conv_engine_2d_cfg
  import conv_engine_2d_cfg_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned COEF_W     = 8,
  parameter int unsigned OUT_W      = 22
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [3:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     coef_wr_en,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic [DATA_W-1:0]        pixel_in,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  output logic signed [OUT_W-1:0]  result_out,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     result_last,
  output logic                     busy,
  output logic                     done_signal
);

  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
  localparam int unsigned EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int unsigned XW     = $clog2(IMG_WIDTH);
  localparam int unsigned YW     = $clog2(IMG_HEIGHT);
  localparam logic signed [EXT_W-1:0] SatMax = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SatMin = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  conv_state_e              state_q;
  logic [XW-1:0]            x_q;
  logic [YW-1:0]            y_q;
  logic [3:0]               shift_q;
  logic                     relu_q, busy_q, done_q;
  logic signed [COEF_W-1:0] coef_q [NumTaps];
  logic signed [PROD_W-1:0] prod_q [NumTaps];
  logic signed [ACC_W-1:0]  row_q [3];
  logic                     v_win_q, last_win_q, v1_q, last1_q, v2_q, last2_q;
  logic                     result_valid_q, result_last_q;
  logic signed [OUT_W-1:0]  result_q, result_d;
  logic signed [ACC_W-1:0]  sum_s, shifted_s;
  logic signed [EXT_W-1:0]  ext_s;
  logic [2:0][2:0][DATA_W-1:0] window;
  logic en, accept, x_last, y_last, in_window, coef_we;

  assign en          = !result_valid_q || result_ready;
  assign pixel_ready = (state_q == StRun) && en;
  assign accept      = pixel_valid && pixel_ready;
  assign x_last      = (x_q == XW'(IMG_WIDTH - 1));
  assign y_last      = (y_q == YW'(IMG_HEIGHT - 1));
  assign in_window   = (x_q >= XW'(2)) && (y_q >= YW'(2));
  assign coef_we     = (state_q == StIdle) && coef_wr_en;

  conv_window_3x3 #(
    .IMG_WIDTH (IMG_WIDTH),
    .DATA_W    (DATA_W)
  ) u_window (
    .clk      (clk),
    .shift_en (accept),
    .pixel_in (pixel_in),
    .window   (window)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (start) begin
          state_q <= StRun;
          busy_q  <= 1'b1;
          shift_q <= cfg_shift;
          relu_q  <= cfg_relu;
          x_q     <= '0;
          y_q     <= '0;
        end
        StRun: if (accept) begin
          if (x_last) begin
            x_q <= '0;
            y_q <= y_last ? '0 : y_q + YW'(1);
            if (y_last) state_q <= StFlush;
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        StFlush: if (!v_win_q && !v1_q && !v2_q && !result_valid_q) begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar t = 0; t < NumTaps; t++) begin : g_tap
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        coef_q[t] <= COEF_W'(SobelXCoef[t]);
      end else if (coef_we && (coef_addr == 4'(t))) begin
        coef_q[t] <= coef_data;
      end
    end

    always_ff @(posedge clk) begin
      if (en) prod_q[t] <= PROD_W'($signed({1'b0, window[t/3][t%3]})) * PROD_W'(coef_q[t]);
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    always_ff @(posedge clk) begin
      if (en) row_q[r] <= ACC_W'(prod_q[3*r]) + ACC_W'(prod_q[3*r+1]) + ACC_W'(prod_q[3*r+2]);
    end
  end

  // Shift, then ReLU, then saturate; compared at EXT_W so OUT_W may exceed ACC_W.
  always_comb begin
    sum_s     = row_q[0] + row_q[1] + row_q[2];
    shifted_s = sum_s >>> shift_q;
    if (relu_q && shifted_s[ACC_W-1]) shifted_s = '0;
    ext_s     = EXT_W'(shifted_s);
    result_d  = OUT_W'(ext_s);
    if (ext_s > SatMax)      result_d = OUT_W'(SatMax);
    else if (ext_s < SatMin) result_d = OUT_W'(SatMin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_win_q        <= 1'b0;
      last_win_q     <= 1'b0;
      v1_q           <= 1'b0;
      last1_q        <= 1'b0;
      v2_q           <= 1'b0;
      last2_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_last_q  <= 1'b0;
      result_q       <= '0;
    end else if (abort) begin
      v_win_q        <= 1'b0;
      last_win_q     <= 1'b0;
      v1_q           <= 1'b0;
      last1_q        <= 1'b0;
      v2_q           <= 1'b0;
      last2_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_last_q  <= 1'b0;
    end else if (en) begin
      v_win_q        <= accept && in_window;
      last_win_q     <= accept && x_last && y_last;
      v1_q           <= v_win_q;
      last1_q        <= last_win_q;
      v2_q           <= v1_q;
      last2_q        <= last1_q;
      result_valid_q <= v2_q;
      result_last_q  <= v2_q && last2_q;
      if (v2_q) result_q <= result_d;
    end
  end

  assign result_out   = result_q;
  assign result_valid = result_valid_q;
  assign result_last  = result_last_q;
  assign busy         = busy_q;
  assign done_signal  = done_q;

endmodule

// File: doc/conv_engine_2d_cfg.md
CONV_ENGINE_2D_CFG -- requirements
Module: conv_engine_2d_cfg

Interface
REQ-001 Parameters: IMG_WIDTH, default 32, frame width in pixels (>=3); IMG_HEIGHT, default 32, frame height (>=3); DATA_W, default 8, unsigned pixel width; COEF_W, default 8, signed coefficient width; OUT_W, default 22, signed result width.
REQ-002 Derived constant: ACC_W = DATA_W+COEF_W+5.
REQ-003 Ports, with clock and reset first:
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, frame start pulse.
- abort, in, 1, synchronous frame cancel.
- cfg_shift, in, 4, arithmetic right shift of the sum.
- cfg_relu, in, 1, clamp negative results to 0.
- coef_wr_en, in, 1, coefficient write strobe.
- coef_addr, in, 4, coefficient index 0..8, row-major, row 0 = oldest line, column 0 = oldest pixel.
- coef_data, in, COEF_W, signed coefficient.
- pixel_in, in, DATA_W, raster-order pixel.
- pixel_valid, in, 1, pixel offered.
- pixel_ready, out, 1, pixel accepted this cycle when high together with pixel_valid.
- result_out, out, OUT_W, signed result.
- result_valid, out, 1, result offered.
- result_ready, in, 1, downstream accepts the result.
- result_last, out, 1, marks the final result of the frame.
- busy, out, 1, high when state is not IDLE.
- done_signal, out, 1, one-cycle end-of-frame pulse.

Function
REQ-004 FSM states are IDLE, RUN, FLUSH, DONE.
REQ-005 IDLE→RUN on start; start SHALL be ignored in all other states.
REQ-006 RUN→FLUSH on acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-007 FLUSH→DONE once no pipeline stage holds valid data and the output register is empty.
REQ-008 DONE→IDLE unconditionally after one cycle; done_signal SHALL be high only in DONE.
REQ-009 abort in any state SHALL force IDLE on the next cycle, clear all pipeline valid bits and the counters, and suppress done_signal.
REQ-010 cfg_shift and cfg_relu SHALL be captured on start and held for the whole frame.
REQ-011 Coefficient writes SHALL take effect only in IDLE; writes in other states and writes with coef_addr>8 are ignored.
REQ-012 Global enable en = !result_valid || result_ready.
- pixel_ready = (state==RUN) && en.
- All pipeline stages advance only when en is high.
REQ-013 Each accepted pixel SHALL shift into two IMG_WIDTH-deep line buffers and the 3x3 window. Column counter x wraps at IMG_WIDTH-1 and increments row counter y.
REQ-014 A result is produced only for accepted pixels with x>=2 and y>=2, giving exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame. No padding is applied.
REQ-015 Window element (r,c) SHALL equal pixel (x-2+c, y-2+r) for the pixel accepted at (x,y).
REQ-016 The pipeline has 3 registered stages:
- Stage 1: nine products, pixel zero-extended × signed coefficient.
- Stage 2: adder tree partial sums.
- Stage 3: final sum at ACC_W, then shift, ReLU and saturation.
REQ-017 result_valid SHALL assert exactly 3 enabled cycles after acceptance of the producing pixel.
REQ-018 Output arithmetic SHALL be applied in this order:
- arithmetic right shift by cfg_shift;
- if cfg_relu, negative values become 0;
- saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-019 While result_valid is high and result_ready is low, result_out and result_last SHALL hold stable.
REQ-020 result_last SHALL accompany the result for window position x=IMG_WIDTH-1, y=IMG_HEIGHT-1.
REQ-021 The line buffers SHALL not be cleared between frames; the x>=2, y>=2 gating makes stale contents unobservable.

Reset
REQ-022 While rst_n is low, the following SHALL hold asynchronously:
- state = IDLE, counters = 0, pipeline valid bits = 0.
- result_out = 0; result_valid, result_last, pixel_ready, busy and done_signal = 0.
- cfg registers = 0.
- coefficients = {1,0,-1, 2,0,-2, 1,0,-1}.
REQ-023 Reset asserted mid-frame SHALL discard the frame; line-buffer and data registers need no reset.

Structure
REQ-024 A shared package SHALL hold the state enum, the default Sobel-X coefficient table, and the ACC_W derivation function.
REQ-025 The 3-row window with its line buffers SHALL be one sub-module, conv_window_3x3, parametrised by IMG_WIDTH and DATA_W, with shift-enable input.

Verification
REQ-026 Reset coefficients, 32x32 frame of constant 10, result_ready=1 → 900 results, all 0, result_last on the 900th, then a single done_signal pulse.
REQ-027 Ramp frame with pixel=x, default coefficients, shift 0 → every result is -8. Same frame with cfg_relu=1 → every result is 0.
REQ-028 Center coefficient set to 1 and all others to 0, random frame → result at window (x,y) equals pixel (x-1,y-1).
REQ-029 All pixels 255, all coefficients 127, OUT_W=16 → every result is 32767. With cfg_shift=4 → every result is 18216.
REQ-030 result_ready toggled pseudo-randomly at 50% → result sequence identical to the result_ready=1 run, no result lost or duplicated, outputs stable while stalled.
REQ-031 abort after 500 accepted pixels → IDLE next cycle, no further results, no done_signal. A following full frame is correct. A coefficient write during RUN has no effect.
